// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: the fetch unit drives a request and address,
// and memory answers with a one-cycle ack strobe that carries the read data.
interface instr_fetch_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// LEGLite instruction-fetch sequencer: one memory read per instruction, a
// one-cycle instr_valid pulse, a PC stall, and sticky misalignment/timeout faults.
module instr_fetch #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic          fault,
  output logic [1:0]    fault_code,
  instr_fetch_if.master mem
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (pc[0]) begin
          state_d      = ERR;
          fault_d      = 1'b1;
          fault_code_d = 2'b01;
        end else begin
          mem_addr_d = pc;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // An ack on the last permitted cycle still completes the fetch.
        if (mem.ack) begin
          instr_d       = mem.rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d    = 1'b0;
          fault_d      = 1'b1;
          fault_code_d = 2'b10;
          state_d      = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        instr_valid_d = 1'b0;
        state_d       = IDLE;
      end
      ERR: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= 2'b00;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      cnt_q         <= cnt_d;
    end
  end

  // The PC may only advance during the single DONE cycle.
  assign stall       = (state_q != DONE);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign mem.req     = mem_req_q;
  assign mem.addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch; expected behaviour comes from
// per-fetch rules (REQ length, latency, fault codes) rather than state tracking.
module tb_instr_fetch;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 16;

  logic          clock;
  logic          reset;
  logic [AW-1:0] pc;
  logic          stall;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          fault;
  logic [1:0]    fault_code;

  int tests = 0;
  int fails = 0;

  instr_fetch_if #(.AW(AW), .DW(DW)) mem_if ();

  instr_fetch #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .mem         (mem_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_req", 32'(mem_if.req), 32'd0);
    check("rst_addr", 32'(mem_if.addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
  endtask

  // Hold reset for two cycles with ack strobing, then release on a falling edge.
  task automatic apply_reset();
    @(negedge clock);
    reset        = 1'b0;
    mem_if.ack   = 1'b1;
    mem_if.rdata = DW'($urandom);
    @(negedge clock);
    mem_if.ack = 1'b0;
    check_reset_state();
    @(negedge clock);
    check_reset_state();
    reset = 1'b1;
    $display("[TB] reset applied");
  endtask

  // Called on a falling edge with the DUT in IDLE. delay = REQ cycle of the
  // ack (1-based); anything above TIMEOUT means memory never answers.
  task automatic do_fetch(input logic [AW-1:0] p, input int delay,
                          input logic [DW-1:0] data, input bit idle_ack,
                          input bit done_ack);
    int  reqc;
    int  cycles;
    int  exp_req;
    bit  ok;
    pc = p;
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_valid", 32'(instr_valid), 32'd0);
    if (idle_ack) begin
      mem_if.ack   = 1'b1;
      mem_if.rdata = ~data;
    end
    @(negedge clock);
    mem_if.ack = 1'b0;
    cycles = 1;

    if (p[0]) begin
      check("mis_fault", 32'(fault), 32'd1);
      check("mis_code", 32'(fault_code), 32'd1);
      check("mis_req", 32'(mem_if.req), 32'd0);
      check("mis_stall", 32'(stall), 32'd1);
      for (int i = 0; i < 3; i++) begin
        mem_if.ack   = 1'b1;
        mem_if.rdata = DW'($urandom);
        @(negedge clock);
        mem_if.ack = 1'b0;
        check("err_fault", 32'(fault), 32'd1);
        check("err_code", 32'(fault_code), 32'd1);
        check("err_req", 32'(mem_if.req), 32'd0);
        check("err_stall", 32'(stall), 32'd1);
        check("err_valid", 32'(instr_valid), 32'd0);
      end
      $display("[TB] fetch pc=%04h misaligned -> fault_code=%0d", p, fault_code);
      apply_reset();
      return;
    end

    reqc = 0;
    while (mem_if.req === 1'b1 && reqc < TIMEOUT + 4) begin
      reqc++;
      check("req_addr", 32'(mem_if.addr), 32'(p));
      check("req_stall", 32'(stall), 32'd1);
      check("req_valid", 32'(instr_valid), 32'd0);
      mem_if.ack   = (reqc == delay);
      mem_if.rdata = (reqc == delay) ? data : DW'($urandom);
      @(negedge clock);
      mem_if.ack = 1'b0;
      cycles++;
    end
    ok      = (delay >= 1 && delay <= TIMEOUT);
    exp_req = ok ? delay : TIMEOUT;
    check("req_cycles", 32'(reqc), 32'(exp_req));

    if (ok) begin
      check("done_valid", 32'(instr_valid), 32'd1);
      check("done_stall", 32'(stall), 32'd0);
      check("done_instr", 32'(instr), 32'(data));
      check("done_fault", 32'(fault), 32'd0);
      cycles++;
      check("cycles_per_instr", 32'(cycles), 32'(delay + 2));
      if (done_ack) begin
        mem_if.ack   = 1'b1;
        mem_if.rdata = ~data;
      end
      @(negedge clock);
      mem_if.ack = 1'b0;
      check("post_valid", 32'(instr_valid), 32'd0);
      check("post_stall", 32'(stall), 32'd1);
      check("post_instr", 32'(instr), 32'(data));
      check("post_req", 32'(mem_if.req), 32'd0);
      $display("[TB] fetch pc=%04h ack@%0d instr=%04h cycles=%0d", p, delay, instr, cycles);
    end else begin
      check("to_fault", 32'(fault), 32'd1);
      check("to_code", 32'(fault_code), 32'd2);
      check("to_req", 32'(mem_if.req), 32'd0);
      check("to_stall", 32'(stall), 32'd1);
      check("to_valid", 32'(instr_valid), 32'd0);
      $display("[TB] fetch pc=%04h no ack -> timeout after %0d req cycles", p, reqc);
      apply_reset();
    end
  endtask

  initial begin
    logic [AW-1:0] rp;
    int            rd;
    reset        = 1'b0;
    pc           = '0;
    mem_if.ack   = 1'b0;
    mem_if.rdata = '0;

    // Reset held with a stray ack
    @(negedge clock);
    mem_if.ack = 1'b1;
    @(negedge clock);
    mem_if.ack = 1'b0;
    check_reset_state();
    reset = 1'b1;
    $display("[TB] initial reset checked");

    do_fetch(16'h0010, 1, 16'hB123, 1'b0, 1'b0);
    do_fetch(16'h0004, 5, 16'h5A5A, 1'b0, 1'b1);
    do_fetch(16'h0020, TIMEOUT, 16'hC0DE, 1'b0, 1'b0);
    do_fetch(16'h0007, 1, 16'h1111, 1'b0, 1'b0);
    do_fetch(16'h0030, TIMEOUT + 1, 16'h2222, 1'b0, 1'b0);

    // Asynchronous reset in the middle of REQ
    pc = 16'h0040;
    @(negedge clock);
    @(negedge clock);
    check("midreq_req_before", 32'(mem_if.req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreq_req_async", 32'(mem_if.req), 32'd0);
    check("midreq_addr_async", 32'(mem_if.addr), 32'd0);
    check("midreq_stall_async", 32'(stall), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    $display("[TB] reset asserted mid-REQ");
    do_fetch(16'h0042, 2, 16'h3C3C, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rp = AW'($urandom);
      rp[0] = ($urandom_range(0, 7) == 0);
      rd = $urandom_range(1, TIMEOUT + 3);
      do_fetch(rp, rd, DW'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
